code_seq_tx: RTL

- Transmitter counterpart of the team's 4-bit code-sequence detector.
- On a start request it drives the unlock sequence 4'b1010 → 4'b1000 → 4'b0111 onto a 4-bit symbol bus, one symbol per clock, repeated a programmable number of times.
- It then returns to an idle code.
- It sits upstream of the detector's `p` input, either in the test harness or as the code source in the keypad path.

---
 rtl/code_seq_tx.sv | 104 ++++++++++
 1 files changed

// File: rtl/code_seq_tx.sv
// code_seq_tx: drives the unlock sequence 1010 -> 1000 -> 0111 onto a 4-bit
// symbol bus, repeated a programmable number of times, then returns to IDLE_CODE.
// Optional feature macro: CODE_SEQ_TX_PARITY_EN adds the registered parity output p_par.
module code_seq_tx #(
   parameter logic [3:0]  IDLE_CODE = 4'b0000,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic [3:0]       p,
   output logic             p_valid,
   output logic             busy,
   output logic             done
`ifdef CODE_SEQ_TX_PARITY_EN
   ,
   output logic             p_par
`endif
);

   typedef enum logic [1:0] {StIdle, StSym1, StSym2, StSym3} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [3:0]       p_d;
   logic             done_d;

   // Next-state, repetition count and completion pulse.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      done_d    = 1'b0;
      if (state_q == StIdle) begin
         // abort wins over a simultaneous start; the start is dropped
         if (start && !abort) begin
            state_d   = StSym1;
            rep_cnt_d = (reps == '0) ? CNT_W'(1) : reps;
         end
      end else if (abort) begin
         state_d   = StIdle;
         rep_cnt_d = '0;
      end else begin
         unique case (state_q)
            StSym1: state_d = StSym2;
            StSym2: state_d = StSym3;
            StSym3: begin
               if (rep_cnt_q > CNT_W'(1)) begin
                  state_d   = StSym1;
                  rep_cnt_d = rep_cnt_q - CNT_W'(1);
               end else begin
                  state_d   = StIdle;
                  rep_cnt_d = '0;
                  done_d    = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Symbol decoded from the next state so p lines up with the state register.
   always_comb begin
      p_d = IDLE_CODE;
      unique case (state_d)
         StSym1:  p_d = 4'b1010;
         StSym2:  p_d = 4'b1000;
         StSym3:  p_d = 4'b0111;
         default: p_d = IDLE_CODE;
      endcase
   end

   // State, count and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         rep_cnt_q <= '0;
         p         <= IDLE_CODE;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rep_cnt_q <= rep_cnt_d;
         p         <= p_d;
         busy      <= (state_d != StIdle);
         done      <= done_d;
      end
   end

   assign p_valid = busy;

`ifdef CODE_SEQ_TX_PARITY_EN
   // Even parity tracks p on the same edge, including reset and idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_par <= ^IDLE_CODE;
      end else begin
         p_par <= ^p_d;
      end
   end
`endif

endmodule
